// File: rtl/hack_pkg.sv
// Shared Hack fetch definitions.
// Widths, reset PC and fetch FSM states.
package hack_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;
  localparam logic [14:0] RESET_PC_DEF = 15'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Hack program counter register.
// Priority: reset > load > increment.
module pc_reg #(
  parameter int          W       = 15,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  // next PC: load wins over increment, wraps modulo 2^W
  always_comb begin
    pc_d = pc_q;
    if (load)
      pc_d = load_val;
    else if (inc)
      pc_d = pc_q + 1'b1;
  end

  // PC state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= RST_VAL;
    else
      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Hack instruction fetch front end.
// One ROM read in flight, valid/ready to the IR stage.
module pc_fetch_unit
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      state_q, state_d;
  logic              squash_q, squash_d;
  logic              rom_req_q, rom_req_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              pc_inc;
  logic [ADDR_W-1:0] fetch_addr;

  pc_reg #(
    .W       (ADDR_W),
    .RST_VAL (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (jump),
    .load_val (jump_addr),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // a jump this cycle retargets the next fetch
  assign fetch_addr = jump ? jump_addr : pc;

  // fetch FSM next-state and output values
  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    ipc_d      = ipc_q;
    pc_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = REQ;
          rom_req_d  = 1'b1;
          rom_addr_d = fetch_addr;
        end
      end
      REQ: begin
        if (rom_ack) begin
          if (squash_q || jump) begin
            squash_d   = 1'b0;
            state_d    = run ? REQ : IDLE;
            rom_req_d  = run;
            rom_addr_d = run ? fetch_addr : rom_addr_q;
          end else begin
            data_d    = rom_data;
            ipc_d     = pc;
            valid_d   = 1'b1;
            pc_inc    = 1'b1;
            state_d   = HOLD;
            rom_req_d = 1'b0;
          end
        end else if (jump) begin
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready || jump) begin
          valid_d    = 1'b0;
          state_d    = run ? REQ : IDLE;
          rom_req_d  = run;
          rom_addr_d = run ? fetch_addr : rom_addr_q;
        end
      end
      default: begin
        state_d   = IDLE;
        rom_req_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // FSM state, squash flag and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      squash_q   <= 1'b0;
      rom_req_q  <= 1'b0;
      rom_addr_q <= RESET_PC;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ipc_q      <= ipc_d;
    end
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign instr_valid = valid_q;
  assign instr_data  = data_q;
  assign instr_pc    = ipc_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction register, which is built from the one-bit register bank.
- Holds the Hack program counter (PC).
- Issues one ROM read at a time and presents each fetched word with a valid/ready handshake to the downstream register stage.
- Handles jump redirects, including squashing an in-flight fetch.

Parameters:
- ADDR_W, 15, PC / ROM address width (32K-word Hack ROM)
- DATA_W, 16, instruction word width
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = fetching enabled; 0 = drain current fetch, then idle
- jump  in  1  single-cycle redirect strobe
- jump_addr  in  ADDR_W  redirect target, sampled when jump=1
- rom_req  out  1  ROM read request, held until rom_ack
- rom_addr  out  ADDR_W  ROM address, stable while rom_req=1
- rom_ack  in  1  single-cycle pulse, rom_data valid in the same cycle; may arrive in the first rom_req cycle
- rom_data  in  DATA_W  ROM read data
- instr_valid  out  1  instr_data/instr_pc valid to downstream
- instr_ready  in  1  downstream accepts when instr_valid & instr_ready
- instr_data  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address the instruction was fetched from
- pc  out  ADDR_W  current architectural PC (next address to fetch)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: pc=RESET_PC, rom_req=0, rom_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0.
  - Internal: state=IDLE, squash=0.
  - Reset asserted mid-fetch abandons the fetch; the ROM tolerates a dropped request.
- State machine (registered):
  - IDLE: rom_req=0. If run=1, go to REQ next cycle with rom_addr=pc.
  - REQ: rom_req=1 and rom_addr=pc. On rom_ack:
    - squash=0: capture rom_data into instr_data and pc into instr_pc, set instr_valid=1, pc<=pc+1, go to HOLD.
    - squash=1: discard data, clear squash, go to REQ if run=1, else IDLE.
  - HOLD: instr_valid=1; instr_data and instr_pc held stable. On instr_ready, clear instr_valid and go to REQ if run=1, else IDLE.
- Latency and throughput:
  - Zero-wait ROM (ack in the first request cycle): instr_valid rises 1 cycle after REQ entry.
  - Peak rate is 1 instruction per 2 cycles. Only one ROM request is ever outstanding.
- PC arithmetic:
  - Increment is modulo 2^ADDR_W: 0x7FFF+1 = 0x0000, no flag.
  - Priority for the pc update: reset > jump > increment.
- Jump handling (pc<=jump_addr in all states):
  - IDLE: next fetch, when run=1, reads jump_addr.
  - REQ before ack: rom_req stays high and rom_addr is unchanged until ack (request never withdrawn). squash=1, so the returning word is dropped. A fresh request to jump_addr is issued the cycle after the ack.
  - REQ same cycle as ack: the acked word is dropped and pc is not incremented. The next request goes to jump_addr.
  - HOLD without instr_ready: instr_valid drops next cycle (word discarded). Go to REQ for jump_addr.
  - HOLD with instr_ready: the handshake completes (word consumed). The next fetch is jump_addr.
- Other boundary rules:
  - A second jump while squash=1 overwrites pc; only one squash is pending.
  - run=0 never aborts an active REQ or HOLD. The unit completes it, then enters IDLE.
  - instr_valid never deasserts without acceptance, except on jump or reset.
  - rom_ack received outside REQ is ignored.

Decomposition:
- Shared package hack_pkg:
  - ADDR_W/DATA_W defaults, RESET_PC.
  - Fetch state enum {IDLE, REQ, HOLD}, 2-bit encoding.
- One sub-module, pc_reg: the Hack PC register with rst_n, load (jump), load value, and inc inputs, applying the reset > load > inc priority. It is instantiated once.
- FSM, squash flag and output register remain in pc_fetch_unit.

Test Plan:
- Zero-wait ROM returning data=addr^0xA5A5, run=1, instr_ready=1 -> instr_pc sequence 0,1,2,3 with instr_data 0xA5A5,0xA5A4,0xA5A7,0xA5A6; instr_valid pulses every 2nd cycle.
- ROM ack delayed 3 cycles, instr_ready=0 for 4 cycles -> rom_addr held stable while rom_req=1; instr_data/instr_pc held; no second request until handshake.
- jump=1, jump_addr=0x0100 while REQ waiting for ack on addr 5 -> ack for 5 produces no instr_valid; next rom_addr=0x0100; first delivered instr_pc=0x0100.
- jump to 0x0200 in HOLD with instr_ready=0 -> instr_valid low next cycle, next delivered instr_pc=0x0200; repeat with instr_ready=1 -> held word consumed, then 0x0200.
- Start with pc forced via jump to 0x7FFE -> delivered instr_pc 0x7FFE, 0x7FFF, 0x0000.
- rst_n low mid-REQ with ack pending, then run=0 -> all outputs at reset values immediately; after release with run=0, rom_req stays 0; run=1 fetches from 0.
